stopwatch_ctrl: RTL

//   Front-panel controller for the stopwatch timer datapath.
//   - Turns three raw button levels (start/stop, lap, clear) into single-cycle start/stop/reset commands for the timer.
//   - Tracks run state.
//   - Captures the timer count into a lap FIFO on each lap press; a downstream display/UART drains the FIFO with a valid/ready handshake.

---
 rtl/stopwatch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button edge detection, run-state FSM,
// registered timer command pulses and a lap-capture FIFO with valid/ready drain.
module stopwatch_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               btn_ss,
    input  logic                               btn_lap,
    input  logic                               btn_clr,
    input  logic [DATA_WIDTH-1:0]              count,
    output logic                               tmr_start,
    output logic                               tmr_stop,
    output logic                               tmr_reset,
    output logic                               running,
    output logic                               lap_valid,
    output logic [DATA_WIDTH-1:0]              lap_data,
    input  logic                               lap_ready,
    output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count,
    output logic                               lap_overflow
);
    // state | meaning
    // IDLE  | timer cleared, lap presses ignored
    // RUN   | timer counting, laps captured
    // PAUSE | timer held, laps still captured

    localparam int PW = $clog2(LAP_DEPTH);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic hist_ss;
    logic hist_lap;
    logic hist_clr;
    logic ev_ss;
    logic ev_lap;
    logic ev_clr;

    logic start_nxt;
    logic stop_nxt;
    logic reset_nxt;

    logic push;
    logic pop;
    logic full;
    logic do_write;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];

    // History resets high so a button held through reset does not fire on release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_ss  <= 1'b1;
            hist_lap <= 1'b1;
            hist_clr <= 1'b1;
        end else begin
            hist_ss  <= btn_ss;
            hist_lap <= btn_lap;
            hist_clr <= btn_clr;
        end
    end

    assign ev_ss  = btn_ss  & ~hist_ss;
    assign ev_lap = btn_lap & ~hist_lap;
    assign ev_clr = btn_clr & ~hist_clr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ev_clr) begin
            state_nxt = IDLE;
        end else if (ev_ss) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // clr swallows any same-cycle ss, so the three commands stay mutually exclusive.
    always_comb begin
        reset_nxt = ev_clr;
        start_nxt = 1'b0;
        stop_nxt  = 1'b0;
        if (!ev_clr && ev_ss) begin
            if (state == RUN) begin
                stop_nxt = 1'b1;
            end else begin
                start_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr_start <= 1'b0;
            tmr_stop  <= 1'b0;
            tmr_reset <= 1'b0;
        end else begin
            tmr_start <= start_nxt;
            tmr_stop  <= stop_nxt;
            tmr_reset <= reset_nxt;
        end
    end

    assign running = (state == RUN);

    assign full      = (lap_count == CW'(LAP_DEPTH));
    assign lap_valid = (lap_count != '0);
    assign pop       = lap_valid & lap_ready;
    assign push      = ev_lap & ~ev_clr & (state != IDLE);
    assign do_write  = push & (~full | pop);
    assign lap_data  = lap_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else if (ev_clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                lap_overflow <= 1'b1;
            end
            if (do_write && !pop) begin
                lap_count <= lap_count + 1'b1;
            end else if (!do_write && pop) begin
                lap_count <= lap_count - 1'b1;
            end
        end
    end

    // When full with a pop, wr_ptr == rd_ptr: the new tail overwrites the head being popped.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= count;
        end
    end

endmodule
